// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: buffers CPU register write-backs in a FIFO and streams each one as a 7-byte frame
// {SYNC_BYTE, pc, addr, data[31:24..7:0]} over a valid/ready byte port.
module cpu_trace_capture #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                        MAX10_CLK1_50,
  input  logic                        reset,
  input  logic                        capture_en,
  input  logic [7:0]                  pc,
  input  logic                        register_write_enable,
  input  logic [4:0]                  write_address,
  input  logic [31:0]                 write_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      r_state, w_next;
  logic [44:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic [44:0] r_frame;
  logic [2:0]  r_idx;
  logic        r_ovf;
  logic [15:0] r_drops;
  logic        w_event, w_full, w_pop, w_push, w_drop, w_send, w_adv;
  logic [7:0]  w_byte;
  assign w_event = capture_en & register_write_enable & (write_address != 5'd0);
  assign w_full  = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_pop   = (r_state == IDLE) && (r_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && !w_push;
  assign w_send  = r_state == SEND;
  assign w_adv   = w_send && out_ready;
  always_comb begin
    w_next = r_state;
    w_next = w_pop ? SEND : w_next;
    w_next = (w_adv && r_idx == 3'd6) ? IDLE : w_next;
  end
  always_comb begin
    w_byte = r_frame[7:0];
    w_byte = (r_idx == 3'd0) ? SYNC_BYTE :
             (r_idx == 3'd1) ? r_frame[44:37] :
             (r_idx == 3'd2) ? {3'b000, r_frame[36:32]} :
             (r_idx == 3'd3) ? r_frame[31:24] :
             (r_idx == 3'd4) ? r_frame[23:16] :
             (r_idx == 3'd5) ? r_frame[15:8] : r_frame[7:0];
  end
  assign out_valid  = w_send;
  assign out_data   = w_send ? w_byte : 8'h00;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign drop_count = r_drops;
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge MAX10_CLK1_50) begin
    if (w_push) r_mem[r_wr] <= {pc, write_address, write_data};
  end
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_frame <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      r_drops <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd    <= r_rd + 1'b1;
        r_frame <= r_mem[r_rd];
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_idx   <= w_pop ? 3'd0 : (w_adv && r_idx != 3'd6) ? r_idx + 3'd1 : r_idx;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb_cpu_trace_capture: directed scenarios plus a random run, all checked against a queue-based
// transaction model of the frame stream.
module tb_cpu_trace_capture;
  logic clk = 1'b0;
  logic rst_n, en, we, ready;
  logic [7:0] pc;
  logic [4:0] wa;
  logic [31:0] wd;
  logic out_valid, overflow;
  logic [7:0] out_data;
  logic [4:0] fifo_count;
  logic [15:0] drop_count;
  int total = 0, bad = 0;
  logic [44:0] m_q[$];
  logic [7:0] m_cur[$];
  bit m_snd = 0, m_ovf = 0;
  int m_drops = 0;

  cpu_trace_capture #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .MAX10_CLK1_50(clk), .reset(rst_n), .capture_en(en), .pc(pc),
    .register_write_enable(we), .write_address(wa), .write_data(wd),
    .out_valid(out_valid), .out_ready(ready), .out_data(out_data),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count));

  always #5 clk = ~clk;

  function automatic logic [7:0] fbyte(logic [44:0] r, int i);
    logic [7:0] b[7];
    b = '{8'hA5, r[44:37], {3'b000, r[36:32]}, r[31:24], r[23:16], r[15:8], r[7:0]};
    return b[i];
  endfunction

  task automatic set_ev(bit e, bit w, logic [4:0] a, logic [7:0] p, logic [31:0] d);
    en = e; we = w; wa = a; pc = p; wd = d;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at that edge.
  task automatic step();
    logic [44:0] rec;
    bit pop, ev;
    int sz;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete(); m_cur.delete(); m_snd = 0; m_ovf = 0; m_drops = 0;
    end else begin
      sz = m_q.size();
      pop = !m_snd && sz > 0;
      ev = en && we && wa != 5'd0;
      if (m_snd && ready) begin
        m_cur.delete(0);
        if (m_cur.size() == 0) m_snd = 0;
      end
      if (pop) begin
        rec = m_q.pop_front();
        for (int i = 0; i < 7; i++) m_cur.push_back(fbyte(rec, i));
        m_snd = 1;
      end
      if (ev) begin
        if (sz < 16 || pop) m_q.push_back({pc, wa, wd});
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; ready = 1; set_ev(0, 0, 0, 0, 0);
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drops got=%0d want=0", drop_count); end
    rst_n = 1;
  endtask

  task automatic test_single();
    logic [7:0] exp[7];
    exp = '{8'hA5, 8'h0C, 8'h09, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ready = 1;
    set_ev(1, 1, 5'd9, 8'h0C, 32'hDEADBEEF);
    step();
    we = 0;
    total++; if (out_valid !== 1'b0 || fifo_count !== 5'd1) begin bad++; $display("FAIL single_push valid=%b count=%0d want valid=0 count=1", out_valid, fifo_count); end
    step();
    for (int i = 0; i < 7; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL single_byte%0d valid=%b data=%h want=%h", i, out_valid, out_data, exp[i]); end
      step();
    end
    total++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin bad++; $display("FAIL single_end valid=%b count=%0d want 0/0", out_valid, fifo_count); end
  endtask

  task automatic test_filter();
    ready = 1;
    set_ev(1, 1, 5'd0, 8'h01, 32'h1); step();
    set_ev(0, 1, 5'd3, 8'h02, 32'h2); step();
    we = 0;
    repeat (4) begin
      total++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin bad++; $display("FAIL filter valid=%b count=%0d want 0/0", out_valid, fifo_count); end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[7];
    exp = '{8'hA5, 8'h22, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ready = 1;
    set_ev(1, 1, 5'd7, 8'h22, 32'hDEADBEEF); step();
    we = 0; step();
    step(); step(); step();
    ready = 0;
    repeat (5) begin
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'hDE) begin bad++; $display("FAIL bp_hold valid=%b data=%h want 1/DE", out_valid, out_data); end
    end
    ready = 1;
    for (int i = 3; i < 7; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL bp_byte%0d valid=%b data=%h want=%h", i, out_valid, out_data, exp[i]); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end valid=%b want=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] got[$];
    int budget;
    logic [31:0] w;
    ready = 0;
    for (int k = 0; k < 20; k++) begin set_ev(1, 1, 5'd1, 8'(k), 32'(k)); step(); end
    we = 0;
    total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", fifo_count); end
    total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL ovf_drops got=%0d want=3", drop_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    ready = 1;
    budget = 300;
    while (got.size() < 17 * 7 && budget > 0) begin
      if (out_valid) got.push_back(out_data);
      step(); budget--;
    end
    total++; if (got.size() != 17 * 7) begin bad++; $display("FAIL ovf_drain got=%0d bytes want=119", got.size()); end
    for (int f = 0; f < 17 && (f * 7 + 6) < got.size(); f++) begin
      w = {got[f*7+3], got[f*7+4], got[f*7+5], got[f*7+6]};
      total++; if (got[f*7] !== 8'hA5 || w !== 32'(f)) begin bad++; $display("FAIL ovf_frame%0d sync=%h data=%h want A5/%h", f, got[f*7], w, f); end
    end
    total++; if (overflow !== 1'b1 || fifo_count !== 5'd0) begin bad++; $display("FAIL ovf_after ovf=%b count=%0d want 1/0", overflow, fifo_count); end
  endtask

  task automatic test_full_pushpop();
    int budget;
    rst_n = 0; step(); rst_n = 1;
    ready = 0;
    for (int k = 0; k < 17; k++) begin set_ev(1, 1, 5'd2, 8'h40, 32'(100 + k)); step(); end
    we = 0;
    total++; if (fifo_count !== 5'd16 || drop_count !== 16'd0) begin bad++; $display("FAIL full_fill count=%0d drops=%0d want 16/0", fifo_count, drop_count); end
    ready = 1;
    budget = 20;
    while (out_valid && budget > 0) begin step(); budget--; end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_idle_timeout valid=%b want=0", out_valid); end
    set_ev(1, 1, 5'd2, 8'h41, 32'hF00D); step();
    total++; if (fifo_count !== 5'd16 || drop_count !== 16'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL full_pushpop count=%0d drops=%0d valid=%b want 16/0/1", fifo_count, drop_count, out_valid); end
    step();
    we = 0;
    total++; if (fifo_count !== 5'd16 || drop_count !== 16'd1 || overflow !== 1'b1) begin bad++; $display("FAIL full_drop count=%0d drops=%0d ovf=%b want 16/1/1", fifo_count, drop_count, overflow); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[7];
    int budget;
    exp = '{8'hA5, 8'h11, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78};
    ready = 1; we = 0;
    budget = 400;
    while ((m_snd || m_q.size() != 0) && budget > 0) begin step(); budget--; end
    ready = 0;
    for (int k = 0; k < 4; k++) begin set_ev(1, 1, 5'd5, 8'h50, 32'h00AB0000 + k); step(); end
    we = 0; ready = 1;
    budget = 20;
    while (!(m_snd && m_cur.size() == 3) && budget > 0) begin step(); budget--; end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hAB || fifo_count !== 5'd3) begin bad++; $display("FAIL mid_byte4 valid=%b data=%h count=%0d want 1/AB/3", out_valid, out_data, fifo_count); end
    rst_n = 0; step(); rst_n = 1;
    total++; if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin bad++; $display("FAIL mid_reset valid=%b count=%0d want 0/0", out_valid, fifo_count); end
    total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("FAIL mid_reset_flags ovf=%b drops=%0d want 0/0", overflow, drop_count); end
    set_ev(1, 1, 5'd4, 8'h11, 32'h12345678); step();
    we = 0; step();
    for (int i = 0; i < 7; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL mid_new_byte%0d valid=%b data=%h want=%h", i, out_valid, out_data, exp[i]); end
      step();
    end
  endtask

  task automatic test_random();
    int thr;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) thr = (c % 800 == 0) ? 90 : 8;
      rst_n = ($urandom_range(0, 599) != 0);
      set_ev($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 5'($urandom_range(0, 3)), 8'($urandom), $urandom);
      ready = ($urandom_range(0, 99) < thr);
      step();
      total++; if (out_valid !== m_snd) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, out_valid, m_snd); end
      total++; if (out_data !== (m_snd ? m_cur[0] : 8'h00)) begin bad++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, out_data, m_snd ? m_cur[0] : 8'h00); end
      total++; if (fifo_count !== 5'(m_q.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, fifo_count, m_q.size()); end
      total++; if (overflow !== m_ovf || drop_count !== 16'(m_drops)) begin bad++; $display("FAIL rnd_drop c=%0d ovf=%b drops=%0d want %b/%0d", c, overflow, drop_count, m_ovf, m_drops); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
